// File: rtl/regbank_pkg.sv
// Shared types and defaults for the register-bank burst reader.
// Holds the FSM encoding and the modulo-NREGS address step.
package regbank_pkg;

  localparam int NREGS_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int DW_DEF    = 2;
  localparam int LW_DEF    = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Wraps at n-1, so non-power-of-2 banks still cycle correctly
  function automatic int next_addr(int a, int n);
    return (a == n - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/regbank_burst_reader_if.sv
// Request and beat channels of the burst reader.
// The reader takes the slave side; the consumer takes master.
interface regbank_burst_reader_if
  import regbank_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  modport master (
    output req_valid, req_addr, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, out_ready,
    output req_ready, out_valid, out_data, out_addr, out_last
  );

endinterface

// File: rtl/regbank_rd_mux.sv
// NREGS:1 register select from the flattened bank.
// Out-of-range addresses return zero.
module regbank_rd_mux
  import regbank_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [NREGS*DW-1:0] reg_data_i,
  input  logic [AW-1:0]       addr_i,
  output logic [DW-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr_i == AW'(i)) begin
        data_o = reg_data_i[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/regbank_burst_reader.sv
// Burst read master: accepts (addr, len) and streams one register
// per beat on a valid/ready channel, wrapping modulo NREGS.
module regbank_burst_reader
  import regbank_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int LW    = LW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREGS*DW-1:0] reg_data,
  input  logic                abort,
  output logic                err,
  regbank_burst_reader_if.slave bus
);

  state_e        state_q, state_d;
  logic          run_q;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;

  logic [AW-1:0] nxt_addr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          accept;
  logic          legal;
  logic          beat_done;

  assign bus.req_ready = run_q && (state_q == IDLE);
  assign accept    = bus.req_valid && bus.req_ready;
  assign legal     = (bus.req_len != '0) &&
                     (int'(bus.req_addr) < NREGS);
  assign beat_done = vld_q && bus.out_ready;
  assign nxt_addr  = AW'(next_addr(int'(addr_q), NREGS));

  // One mux serves both the first beat and every follow-on beat
  assign sel_addr = (state_q == IDLE) ? bus.req_addr : nxt_addr;

  regbank_rd_mux #(
    .NREGS(NREGS),
    .AW   (AW),
    .DW   (DW)
  ) u_mux (
    .reg_data_i(reg_data),
    .addr_i    (sel_addr),
    .data_o    (sel_data)
  );

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (accept && legal) begin
          state_d = BURST;
          vld_d   = 1'b1;
          data_d  = sel_data;
          addr_d  = bus.req_addr;
          rem_d   = bus.req_len - 1'b1;
          last_d  = (bus.req_len == LW'(1));
        end else if (accept) begin
          err_d = 1'b1;
        end
      end
      BURST: begin
        if (abort || (beat_done && rem_q == '0)) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
        end else if (beat_done) begin
          addr_d = nxt_addr;
          data_d = sel_data;
          rem_d  = rem_q - 1'b1;
          last_d = (rem_q == LW'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      err_q   <= err_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign err          = err_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_regbank_burst_reader.sv
// Bench for regbank_burst_reader: directed sequences, a burst table
// and random traffic against a beat-index reference model.
module tb_regbank_burst_reader;

  logic        clk;
  logic        rst;
  logic [15:0] bank8;
  logic [19:0] bank10;
  logic        abort8, abort10;
  logic        err8, err10;

  regbank_burst_reader_if #(.AW(3), .DW(2), .LW(4)) bus8 ();
  regbank_burst_reader_if #(.AW(4), .DW(2), .LW(4)) bus10 ();

  regbank_burst_reader #(.NREGS(8), .AW(3), .DW(2), .LW(4)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .reg_data(bank8),
    .abort   (abort8),
    .err     (err8),
    .bus     (bus8)
  );

  regbank_burst_reader #(.NREGS(10), .AW(4), .DW(2), .LW(4)) dut10 (
    .clk     (clk),
    .rst     (rst),
    .reg_data(bank10),
    .abort   (abort10),
    .err     (err10),
    .bus     (bus10)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  // Reference: a burst is (base, len); beat k sits at (base+k)%8 and
  // its data is the bank value at the edge that loaded it.
  bit          m_busy, m_run, m_err;
  int          m_base, m_len, m_idx;
  logic [1:0]  m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_run  <= 1'b0;
      m_err  <= 1'b0;
      m_base <= 0;
      m_len  <= 0;
      m_idx  <= 0;
      m_data <= 2'b00;
    end else begin
      m_run <= 1'b1;
      m_err <= 1'b0;
      if (!m_busy) begin
        if (bus8.req_valid && m_run) begin
          if (bus8.req_len == 0 || int'(bus8.req_addr) >= 8) begin
            m_err <= 1'b1;
          end else begin
            m_busy <= 1'b1;
            m_base <= int'(bus8.req_addr);
            m_len  <= int'(bus8.req_len);
            m_idx  <= 0;
            m_data <= bank8[int'(bus8.req_addr)*2 +: 2];
          end
        end
      end else if (abort8) begin
        m_busy <= 1'b0;
      end else if (bus8.out_ready) begin
        if (m_idx == m_len - 1) begin
          m_busy <= 1'b0;
        end else begin
          m_idx  <= m_idx + 1;
          m_data <= bank8[((m_base + m_idx + 1) % 8)*2 +: 2];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst) begin
      chk("m_valid", bus8.out_valid, m_busy);
      chk("m_ready", bus8.req_ready, m_run && !m_busy);
      chk("m_err", err8, m_err);
      if (m_busy) begin
        chk("m_addr", bus8.out_addr, (m_base + m_idx) % 8);
        chk("m_data", bus8.out_data, m_data);
        chk("m_last", bus8.out_last, m_idx == m_len - 1);
      end else begin
        chk("m_last0", bus8.out_last, 0);
      end
    end
  end

  typedef struct {
    logic [2:0] addr;
    logic [3:0] len;
    bit         exp_err;
    int         exp_beats;
    logic [2:0] exp_last;
  } vec_t;

  vec_t       tbl[7];
  bit         pat[5];
  logic [2:0] seen[5];
  int         nb;
  logic [1:0] old1;
  bit         got_err;
  logic [2:0] lasta;
  int         exp10[4];

  task automatic req8(input logic [2:0] a, input logic [3:0] l);
    bus8.req_valid = 1'b1;
    bus8.req_addr  = a;
    bus8.req_len   = l;
  endtask

  task automatic req10(input logic [3:0] a, input logic [3:0] l);
    bus10.req_valid = 1'b1;
    bus10.req_addr  = a;
    bus10.req_len   = l;
  endtask

  initial begin
    tbl[0] = '{3'd3, 4'd1,  1'b0, 1,  3'd3};
    tbl[1] = '{3'd6, 4'd4,  1'b0, 4,  3'd1};
    tbl[2] = '{3'd2, 4'd0,  1'b1, 0,  3'd0};
    tbl[3] = '{3'd7, 4'd2,  1'b0, 2,  3'd0};
    tbl[4] = '{3'd5, 4'd15, 1'b0, 15, 3'd3};
    tbl[5] = '{3'd0, 4'd8,  1'b0, 8,  3'd7};
    tbl[6] = '{3'd4, 4'd3,  1'b0, 3,  3'd6};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    bank8 = 16'hB4E1;
    bank10 = 20'h9C6E5;
    abort8 = 1'b0;
    abort10 = 1'b0;
    bus8.req_valid = 1'b0;
    bus8.req_addr = '0;
    bus8.req_len = '0;
    bus8.out_ready = 1'b0;
    bus10.req_valid = 1'b0;
    bus10.req_addr = '0;
    bus10.req_len = '0;
    bus10.out_ready = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", bus8.out_valid, 0);
    chk("rst_ready", bus8.req_ready, 0);
    chk("rst_err", err8, 0);
    chk("rst_data", bus8.out_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus8.req_ready, 1);
    chk_on = 1'b1;

    // single beat
    bank8[6 +: 2] = 2'b10;
    bus8.out_ready = 1'b1;
    req8(3'd3, 4'd1);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    chk("t2_valid", bus8.out_valid, 1);
    chk("t2_data", bus8.out_data, 2'b10);
    chk("t2_addr", bus8.out_addr, 3);
    chk("t2_last", bus8.out_last, 1);
    chk("t2_busy", bus8.req_ready, 0);
    @(negedge clk);
    chk("t2_end", bus8.out_valid, 0);
    chk("t2_ready", bus8.req_ready, 1);

    // wrap 6,7,0,1
    req8(3'd6, 4'd4);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_valid", bus8.out_valid, 1);
      chk("t3_addr", bus8.out_addr, (6 + k) % 8);
      chk("t3_last", bus8.out_last, k == 3);
      @(negedge clk);
    end
    chk("t3_end", bus8.out_valid, 0);

    // backpressure with bank change during stall
    old1 = bank8[2 +: 2];
    bus8.out_ready = 1'b0;
    req8(3'd0, 4'd3);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    nb = 0;
    for (int p = 0; p < 5; p++) begin
      if (p == 2) begin
        chk("t4_hold_d", bus8.out_data, old1);
        chk("t4_hold_a", bus8.out_addr, 1);
      end
      bus8.out_ready = pat[p];
      if (bus8.out_valid && pat[p] && nb < 5) begin
        seen[nb] = bus8.out_addr;
        nb++;
      end
      if (p == 1) bank8[2 +: 2] = ~old1;
      @(negedge clk);
    end
    chk("t4_beats", nb, 3);
    chk("t4_a0", seen[0], 0);
    chk("t4_a1", seen[1], 1);
    chk("t4_a2", seen[2], 2);
    chk("t4_end", bus8.out_valid, 0);

    // reject len=0
    req8(3'd1, 4'd0);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    chk("t5_err", err8, 1);
    chk("t5_valid", bus8.out_valid, 0);
    chk("t5_ready", bus8.req_ready, 1);
    @(negedge clk);
    chk("t5_err_off", err8, 0);

    // reject addr 10 and wrap 8,9,0,1 on the 10-entry bank
    req10(4'd10, 4'd2);
    @(negedge clk);
    bus10.req_valid = 1'b0;
    chk("t5b_err", err10, 1);
    chk("t5b_valid", bus10.out_valid, 0);
    chk("t5b_ready", bus10.req_ready, 1);
    @(negedge clk);
    chk("t5b_off", err10, 0);
    exp10 = '{8, 9, 0, 1};
    req10(4'd8, 4'd4);
    @(negedge clk);
    bus10.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("w10_valid", bus10.out_valid, 1);
      chk("w10_addr", bus10.out_addr, exp10[k]);
      chk("w10_data", bus10.out_data, bank10[exp10[k]*2 +: 2]);
      chk("w10_last", bus10.out_last, k == 3);
      @(negedge clk);
    end
    chk("w10_end", bus10.out_valid, 0);

    // abort coincident with beat 2 handshake
    bus8.out_ready = 1'b1;
    req8(3'd2, 4'd5);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    chk("t6_b1", bus8.out_addr, 2);
    @(negedge clk);
    chk("t6_b2", bus8.out_addr, 3);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    chk("t6_stop", bus8.out_valid, 0);
    chk("t6_ready", bus8.req_ready, 1);
    abort8 = 1'b1;
    req8(3'd5, 4'd2);
    @(negedge clk);
    abort8 = 1'b0;
    bus8.req_valid = 1'b0;
    chk("t6_new", bus8.out_valid, 1);
    chk("t6_new_a", bus8.out_addr, 5);
    repeat (2) @(negedge clk);

    // burst table, out_ready held high
    for (int i = 0; i < 7; i++) begin
      req8(tbl[i].addr, tbl[i].len);
      @(negedge clk);
      bus8.req_valid = 1'b0;
      got_err = err8;
      nb = 0;
      lasta = '0;
      for (int c = 0; c < 40 && bus8.out_valid; c++) begin
        nb++;
        if (bus8.out_last) lasta = bus8.out_addr;
        @(negedge clk);
      end
      chk("tbl_err", got_err, tbl[i].exp_err);
      chk("tbl_beats", nb, tbl[i].exp_beats);
      chk("tbl_last", lasta, tbl[i].exp_last);
      @(negedge clk);
    end

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus8.req_valid = ($urandom_range(0, 1) == 1);
      bus8.req_addr = 3'($urandom_range(0, 7));
      bus8.req_len = 4'($urandom_range(0, 15));
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      abort8 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) bank8 = 16'($urandom);
    end
    @(negedge clk);
    abort8 = 1'b0;
    bus8.req_valid = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (20) @(negedge clk);

    // reset mid-burst
    bus8.out_ready = 1'b0;
    req8(3'd4, 4'd6);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    chk("t1_pre", bus8.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_valid", bus8.out_valid, 0);
    chk("t1_data", bus8.out_data, 0);
    chk("t1_addr", bus8.out_addr, 0);
    chk("t1_last", bus8.out_last, 0);
    chk("t1_err", err8, 0);
    chk("t1_ready", bus8.req_ready, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_rel0", bus8.req_ready, 0);
    @(negedge clk);
    chk("t1_rel1", bus8.req_ready, 1);
    chk("t1_novld", bus8.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
